xnor_seq_matcher: RTL and testbench
===================================

# xnor_seq_matcher

Serial pattern matcher that sits downstream of the 1-bit `xnor_gate` cell. A generate loop instantiates one `xnor_gate` per window bit to compare a sliding window of a serial bit stream against a programmable pattern. The block:
- pulses `match` on every exact (overlapping) occurrence of the pattern;
- keeps a saturating count of matches;
- reports how many bits of the current window agree with the pattern.

## Interface
- `WIDTH`, 8, pattern/window length in bits (2..32)
- `CNT_W`, 8, width of the match counter
- `clk`  input  1  single clock; all state updates on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `pat_load`  input  1  load `pat_in` as new pattern this cycle
- `pat_in`  input  WIDTH  pattern; MSB compares with the oldest window bit
- `bit_valid`  input  1  `bit_in` is valid this cycle
- `bit_in`  input  1  serial data bit
- `armed`  output  1  pattern loaded and window full (state RUN)
- `match`  output  1  one-cycle pulse on exact match
- `match_count`  output  CNT_W  saturating number of matches since last load/reset
- `agree_bits`  output  $clog2(WIDTH+1)  popcount of XNOR(window, pattern) in RUN, else 0

## Operation
- States:
  - IDLE: no pattern loaded.
  - FILL: pattern loaded, fewer than WIDTH bits accepted since load.
  - RUN: window full, detection active.
- IDLE -> FILL on `pat_load`.
- FILL -> RUN when the WIDTH-th bit since load is accepted.
- Any state -> FILL on `pat_load`, which reloads the pattern.
- No other transitions.
- Bit acceptance: `bit_valid`=1 and `pat_load`=0 in IDLE/FILL/RUN.
  - In IDLE, accepted bits shift into the window but are otherwise ignored.
- Window shift: window <= {window[WIDTH-2:0], bit_in}, so the newest bit is at the LSB.
- `pat_load`: pattern <= `pat_in`; window, fill counter and `match_count` clear to 0.
  - `pat_load` wins over `bit_valid` in the same cycle, and that bit is dropped.
- Match condition: post-shift window == pattern (all XNOR outputs 1), evaluated only on an acceptance edge in RUN or on the FILL->RUN edge.
  - Overlapping occurrences each count.
- `match_count` increments on each match and holds at 2^CNT_W-1.
- FILL suppresses detection. A zero-cleared window must never match pattern 0 before WIDTH real bits have arrived.
- `agree_bits` is combinational from registered window/pattern and is 0 outside RUN.

## Timing
- Reset values: `armed`=0, `match`=0, `match_count`=0, `agree_bits`=0, state IDLE, window=0, pattern=0.
- `match` is registered. It is high for exactly the one cycle after the edge that accepts the completing bit (latency 1 clk from sampling `bit_in`).
- `match_count` updates on the same edge that sets `match`.
- `armed` rises in the cycle after the edge that accepts the WIDTH-th bit, and falls in the cycle after a `pat_load` edge.
- Idle cycles (`bit_valid`=0) leave window, counter and state unchanged. `match` returns to 0.
- Reset asserted mid-stream clears all outputs immediately, without waiting for a clock edge. The first edge after deassertion behaves as IDLE.

## Structure
- Package `xnor_pkg`:
  - state enum `matcher_state_t` {IDLE, FILL, RUN};
  - localparam default WIDTH;
  - function `popcount`.
- Bitwise compare: generate loop of WIDTH `xnor_gate` instances.
- One natural sub-module: `xnor_agree_count`, which takes window and pattern and returns the XNOR vector, its popcount and the all-ones flag.
- The FSM, fill counter, shift register and saturating counter live in the top module.

## Test plan
- Reset: hold `rst`=1 for 3 clks with random inputs -> all outputs 0, `armed`=0. Assert `rst` mid-stream -> outputs 0 within the same cycle, without a clock edge.
- Basic: load 8'hA5, feed 1,0,1,0,0,1,0,1 -> `armed`=1 and `match`=1 for one cycle after the 8th bit, `match_count`=1, `agree_bits`=8.
- Overlap: load 8'hFF, feed nine 1s -> match pulses after bits 8 and 9, `match_count`=2. Gaps of `bit_valid`=0 between bits change nothing.
- Fill guard: load 8'h00, feed seven 0s -> no match, `armed`=0, `agree_bits`=0. The 8th 0 -> match, `match_count`=1.
- Priority/reload: `pat_load`=1 with `bit_valid`=1 -> bit dropped, counter 0, state FILL. Afterwards 8 more bits are required before any match.
- Saturation: CNT_W=2, pattern 8'hFF, feed twelve 1s -> `match_count` stops at 3 while `match` keeps pulsing.

Source files
------------

// File: rtl/xnor_seq_matcher_pkg.sv
// -----------------------------------------------------------------------------
// xnor_pkg
// Shared types and helpers for the serial XNOR pattern matcher.
//   matcher_state_t : IDLE (no pattern), FILL (window filling), RUN (detecting)
//   DEFAULT_WIDTH   : default pattern/window length
//   popcount()      : number of set bits in a 32-bit vector
// -----------------------------------------------------------------------------
package xnor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } matcher_state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/xnor_gate.sv
// -----------------------------------------------------------------------------
// xnor_gate
// 1-bit equality cell.
//   i_a, i_b : operand bits
//   o_y      : 1 when i_a == i_b
// -----------------------------------------------------------------------------
module xnor_gate (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);

    assign o_y = ~(i_a ^ i_b);

endmodule

// File: rtl/xnor_seq_matcher_agree.sv
// -----------------------------------------------------------------------------
// xnor_agree_count
// Bitwise compare of a window against a pattern using one xnor_gate per bit.
//   i_window   : window bits
//   i_pattern  : pattern bits
//   o_xnor     : per-bit agreement vector
//   o_agree    : number of agreeing bits
//   o_all_ones : every bit agrees (exact match)
// -----------------------------------------------------------------------------
module xnor_agree_count
    import xnor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]         i_window,
    input  logic [WIDTH-1:0]         i_pattern,
    output logic [WIDTH-1:0]         o_xnor,
    output logic [$clog2(WIDTH+1)-1:0] o_agree,
    output logic                     o_all_ones
);

    localparam int unsigned AW = $clog2(WIDTH + 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xnor_gate u_xnor (
            .i_a (i_window[i]),
            .i_b (i_pattern[i]),
            .o_y (o_xnor[i])
        );
    end

    assign o_agree    = AW'(popcount(32'(o_xnor)));
    assign o_all_ones = &o_xnor;

endmodule

// File: rtl/xnor_seq_matcher.sv
// -----------------------------------------------------------------------------
// xnor_seq_matcher
// Serial pattern matcher: slides a WIDTH-bit window over a bit stream and
// compares it against a programmable pattern.
//   clk, rst     : clock, asynchronous active-high reset
//   pat_load     : load pat_in as new pattern (clears window/fill/count)
//   pat_in       : pattern, MSB compares with the oldest window bit
//   bit_valid    : bit_in is valid this cycle
//   bit_in       : serial data bit (shifted in at the LSB)
//   armed        : state RUN (pattern loaded and window full)
//   match        : one-cycle registered pulse on an exact match
//   match_count  : saturating number of matches since load/reset
//   agree_bits   : agreeing bit count in RUN, else 0
// -----------------------------------------------------------------------------
module xnor_seq_matcher
    import xnor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pat_load,
    input  logic [WIDTH-1:0]           pat_in,
    input  logic                       bit_valid,
    input  logic                       bit_in,
    output logic                       armed,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(WIDTH+1)-1:0] agree_bits
);

    localparam int unsigned    AW        = $clog2(WIDTH + 1);
    localparam int unsigned    FW        = $clog2(WIDTH);
    localparam logic [FW-1:0]  FILL_LAST = FW'(WIDTH - 1);

    matcher_state_t   r_state;
    logic [WIDTH-1:0] r_window;
    logic [WIDTH-1:0] r_pattern;
    logic [FW-1:0]    r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_count;
    logic [AW-1:0]    r_agree;

    logic [WIDTH-1:0] w_d_window;
    logic [WIDTH-1:0] w_d_pattern;
    logic [WIDTH-1:0] w_xnor_unused;
    logic [AW-1:0]    w_d_agree;
    logic             w_d_all_ones;
    logic             w_detect;

    // Next-edge window/pattern values; pat_load wins and drops the bit.
    always_comb begin
        w_d_window  = r_window;
        w_d_pattern = r_pattern;
        if (pat_load) begin
            w_d_window  = '0;
            w_d_pattern = pat_in;
        end else if (bit_valid) begin
            w_d_window = {r_window[WIDTH-2:0], bit_in};
        end
    end

    // The compare array sees the values about to be registered: its all-ones
    // flag is the post-shift match, and its popcount registered here equals
    // the popcount of the registered window/pattern in every cycle.
    xnor_agree_count #(
        .WIDTH (WIDTH)
    ) u_agree (
        .i_window   (w_d_window),
        .i_pattern  (w_d_pattern),
        .o_xnor     (w_xnor_unused),
        .o_agree    (w_d_agree),
        .o_all_ones (w_d_all_ones)
    );

    // Detection only on an accepted bit in RUN or on the completing FILL bit;
    // this keeps a cleared window from matching an all-zero pattern early.
    assign w_detect = bit_valid && !pat_load && w_d_all_ones &&
                      ((r_state == RUN) ||
                       ((r_state == FILL) && (r_fill == FILL_LAST)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_window  <= '0;
            r_pattern <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_agree   <= AW'(WIDTH);
        end else begin
            r_window  <= w_d_window;
            r_pattern <= w_d_pattern;
            r_agree   <= w_d_agree;
            r_match   <= w_detect;
            if (pat_load) begin
                r_state <= FILL;
                r_fill  <= '0;
                r_count <= '0;
            end else begin
                if (w_detect && (r_count != '1)) begin
                    r_count <= r_count + CNT_W'(1);
                end
                if (bit_valid) begin
                    case (r_state)
                        IDLE: r_state <= IDLE;
                        FILL: begin
                            if (r_fill == FILL_LAST) begin
                                r_state <= RUN;
                            end else begin
                                r_fill <= r_fill + FW'(1);
                            end
                        end
                        RUN:     r_state <= RUN;
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign armed       = (r_state == RUN);
    assign match       = r_match;
    assign match_count = r_count;
    assign agree_bits  = armed ? r_agree : '0;

endmodule

// File: tb/tb_xnor_seq_matcher.sv
// -----------------------------------------------------------------------------
// tb_xnor_seq_matcher
// Drives two matchers (CNT_W=8 and CNT_W=2) with identical stimulus and
// compares both against a queue-of-bits reference model through a scoreboard.
// -----------------------------------------------------------------------------
module tb_xnor_seq_matcher;

    localparam int W = 8;

    typedef struct {
        int match;
        int cnt8;
        int cnt2;
        int armed;
        int agree;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pat_load;
    logic [7:0] pat_in;
    logic       bit_valid;
    logic       bit_in;

    logic       a8, m8, as2, ms2;
    logic [7:0] c8;
    logic [1:0] cs2;
    logic [3:0] g8, gs2;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];

    // reference model state
    bit       m_loaded;
    bit [7:0] m_pat;
    bit       m_bits[$];
    int       m_cnt8, m_cnt2, m_match;

    always #5 clk = ~clk;

    xnor_seq_matcher #(.WIDTH(8), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .pat_load(pat_load), .pat_in(pat_in),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .armed(a8), .match(m8), .match_count(c8), .agree_bits(g8)
    );

    xnor_seq_matcher #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .pat_load(pat_load), .pat_in(pat_in),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .armed(as2), .match(ms2), .match_count(cs2), .agree_bits(gs2)
    );

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_loaded = 1'b0;
        m_pat    = '0;
        m_bits.delete();
        m_cnt8   = 0;
        m_cnt2   = 0;
        m_match  = 0;
    endfunction

    // agreement of the last W accepted bits with the pattern, oldest vs MSB
    function automatic int model_agree();
        int a = 0;
        for (int i = 0; i < m_bits.size(); i++) begin
            if (m_bits[i] == m_pat[W-1-i]) a++;
        end
        return a;
    endfunction

    function automatic void model_edge(input logic pl, input logic [7:0] pi,
                                       input logic bv, input logic bi);
        bit dummy;
        m_match = 0;
        if (pl) begin
            m_loaded = 1'b1;
            m_pat    = pi;
            m_bits.delete();
            m_cnt8   = 0;
            m_cnt2   = 0;
        end else if (bv && m_loaded) begin
            m_bits.push_back(bi);
            if (m_bits.size() > W) dummy = m_bits.pop_front();
            if (m_bits.size() == W && model_agree() == W) begin
                m_match = 1;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.match = m_match;
        e.cnt8  = m_cnt8;
        e.cnt2  = m_cnt2;
        e.armed = (m_loaded && m_bits.size() == W) ? 1 : 0;
        e.agree = e.armed ? model_agree() : 0;
        return e;
    endfunction

    // One clock of stimulus; expectation for the post-edge outputs is queued.
    task automatic step(input logic pl, input logic [7:0] pi,
                        input logic bv, input logic bi);
        pat_load  = pl;
        pat_in    = pi;
        bit_valid = bv;
        bit_in    = bi;
        @(posedge clk);
        model_edge(pl, pi, bv, bi);
        exp_q.push_back(model_outputs());
        #1;
        pat_load  = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " armed8"}, int'(a8), 0);
        chk({tag, " match8"}, int'(m8), 0);
        chk({tag, " count8"}, int'(c8), 0);
        chk({tag, " agree8"}, int'(g8), 0);
        chk({tag, " armed2"}, int'(as2), 0);
        chk({tag, " count2"}, int'(cs2), 0);
    endtask

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb match8", int'(m8),  e.match);
                chk("sb match2", int'(ms2), e.match);
                chk("sb armed8", int'(a8),  e.armed);
                chk("sb armed2", int'(as2), e.armed);
                chk("sb count8", int'(c8),  e.cnt8);
                chk("sb count2", int'(cs2), e.cnt2);
                chk("sb agree8", int'(g8),  e.agree);
                chk("sb agree2", int'(gs2), e.agree);
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int k;
        rst       = 1'b1;
        pat_load  = 1'b0;
        pat_in    = '0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        model_reset();

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            pat_load  = 1'($urandom);
            pat_in    = 8'($urandom);
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            #1;
            chk_all_zero("reset hold");
        end
        @(negedge clk);
        pat_load  = 1'b0;
        bit_valid = 1'b0;
        rst       = 1'b0;

        // basic: A5 = 1,0,1,0,0,1,0,1
        pat = 8'hA5;
        step(1'b1, pat, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, '0, 1'b1, pat[i]);
            if (i == 1) chk("basic armed before 8th", int'(a8), 0);
        end
        chk("basic match",  int'(m8), 1);
        chk("basic count",  int'(c8), 1);
        chk("basic agree",  int'(g8), 8);
        chk("basic armed",  int'(a8), 1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("basic match drops", int'(m8), 0);

        // asynchronous reset mid-stream, no clock edge in between
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b0, '0, 1'b1, 1'b1);
        chk("post reset idle armed", int'(a8), 0);

        // overlap with gaps
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, '0, 1'b1, 1'b1);
            if (i == 8) begin
                chk("overlap match 8", int'(m8), 1);
                chk("overlap count 8", int'(c8), 1);
            end
            step(1'b0, '0, 1'b0, 1'b0);
            if (i == 8) begin
                chk("overlap gap match", int'(m8), 0);
                chk("overlap gap count", int'(c8), 1);
            end
        end
        chk("overlap count 9", int'(c8), 2);

        // fill guard with all-zero pattern
        step(1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        chk("fillguard match", int'(m8), 0);
        chk("fillguard armed", int'(a8), 0);
        chk("fillguard agree", int'(g8), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fillguard match 8", int'(m8), 1);
        chk("fillguard count 8", int'(c8), 1);

        // reload wins over a valid bit
        step(1'b1, 8'hFF, 1'b1, 1'b1);
        chk("reload count", int'(c8), 0);
        chk("reload armed", int'(a8), 0);
        for (int i = 1; i <= 7; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("reload no early match", int'(m8), 0);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("reload match 8", int'(m8), 1);
        chk("reload count 8", int'(c8), 1);

        // saturation of the 2-bit counter
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) step(1'b0, '0, 1'b1, 1'b1);
        chk("sat count2", int'(cs2), 3);
        chk("sat match2", int'(ms2), 1);
        chk("sat count8", int'(c8), 5);

        // randomized segments, bits biased towards the pattern sequence
        for (int s = 0; s < 25; s++) begin
            case ($urandom_range(3))
                0:       pat = 8'hFF;
                1:       pat = 8'h00;
                2:       pat = 8'hAA;
                default: pat = 8'($urandom);
            endcase
            step(1'b1, pat, 1'($urandom), 1'($urandom));
            k = 0;
            for (int c = 0; c < 60; c++) begin
                logic bv, bi;
                bv = ($urandom_range(3) != 0);
                bi = ($urandom_range(3) != 0) ? pat[7 - (k % 8)] : 1'($urandom);
                if ($urandom_range(59) == 0) begin
                    step(1'b1, pat, bv, bi);
                    k = 0;
                end else begin
                    step(1'b0, '0, bv, bi);
                    if (bv) k++;
                end
            end
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
